exec_mem_unit: RTL and testbench
================================

// Module: exec_mem_unit
// PURPOSE
// - Execute/memory slice of the single-cycle 32-bit MIPS datapath: immediate extender, ALU, byte-addressed data memory.
// - All three are independent sub-paths. The datapath top wires ext_out to alu_b via its ALUSrc mux, alu_out to mem_addr, and busB to mem_wdata.
// - Everything is combinational except the data-memory write and reset-clear.
// PARAMETERS
// - DM_AW  10  log2 of data-memory depth in 32-bit words (1024 words = 4 KiB)
// PORTS
// - clk         in   1   clock; DM updates on rising edge
// - reset       in   1   synchronous, active-low reset (0 = reset), sampled on rising clk
// - ext_op      in   1   1 = sign-extend imm16, 0 = zero-extend
// - imm16       in   16  instruction immediate
// - ext_out     out  32  extended immediate
// - alu_a       in   32  operand A (rs value, or zero-extended shamt for SLL/SRL/SRA)
// - alu_b       in   32  operand B (rt value or ext_out)
// - alu_ctr     in   5   ALU operation select
// - alu_out     out  32  ALU result
// - alu_zero    out  1   1 when alu_out == 0
// - alu_ovf     out  1   signed overflow of ADD/SUB
// - mem_wr      in   1   store enable
// - mem_addr    in   32  byte address
// - mem_wdata   in   32  store data (rt)
// - mem_opcode  in   6   instruction opcode bits [31:26], selects access size
// - mem_rdata   out  32  load data, combinational
// BEHAVIOUR
// - Ext: ext_out = ext_op ? {{16{imm16[15]}},imm16} : {16'b0,imm16}.
// - ALU ops (alu_ctr):
//   - 0 ADDU; 1 ADD; 2 SUBU (a-b); 3 SUB; 4 AND; 5 OR; 6 XOR; 7 NOR
//   - 8 SLT signed (out = 1/0); 9 SLTU unsigned
//   - 10 SLL b<<a[4:0]; 11 SRL logical b>>a[4:0]; 12 SRA arithmetic b>>>a[4:0]; 13 LUI {b[15:0],16'b0}
//   - 14-31: alu_out = 0
// - ALU arithmetic is modulo 2^32. ADD/SUB produce the wrapped result even on overflow; the register-write decision belongs to control.
// - alu_ovf = 1 only for ops 1/3 when operand signs imply signed overflow, else 0.
// - alu_zero reflects alu_out for every op, including undefined codes (1).
// - DM storage: 2^DM_AW words, little-endian byte lanes.
//   - Word index = mem_addr[DM_AW+1:2]; higher address bits ignored (wrap).
//   - Byte lane = mem_addr[1:0]; half lane = mem_addr[1]; misaligned low bits ignored.
// - Loads (combinational, independent of mem_wr):
//   - 0x20 LB sign-extended byte; 0x24 LBU zero-extended byte
//   - 0x21 LH sign-extended half; 0x25 LHU zero-extended half
//   - any other opcode: full word
// - Stores at rising clk when reset==1 && mem_wr==1:
//   - 0x28 SB writes byte lane from mem_wdata[7:0]
//   - 0x29 SH writes half lane from mem_wdata[15:0]
//   - any other opcode: full word
//   - untouched lanes keep their value
// - Read-during-write: mem_rdata shows old contents until the edge, new contents after.
// - Reset: rising clk with reset==0 clears every DM word to 0; a concurrent mem_wr is ignored.
//   - Ext/ALU outputs have no state and follow inputs during reset.
//   - Reset asserted mid-operation takes effect at the next edge only.
// CONFIGURATION
// - Macro ALU_OVF_EN:
//   - defined: alu_ovf computed as above
//   - undefined: alu_ovf tied 0; ADD/SUB behave identically to ADDU/SUBU
// STRUCTURE
// - Shared package exec_pkg: ALU op localparams (ALU_ADDU..ALU_LUI); opcode localparams (OP_LB, OP_LH, OP_LBU, OP_LHU, OP_SB, OP_SH).
// - One natural sub-module: exec_dm_ram (byte-lane-enable RAM with sync reset-clear and async read). Ext and ALU stay inline.
// TESTING
// - ext_op=1, imm16=16'h8001 -> ext_out=32'hFFFF8001; ext_op=0 -> 32'h00008001.
// - ALU ops, with alu_a=32'h7FFFFFFF, alu_b=1:
//   - ADD -> alu_out=32'h80000000, alu_ovf=1 (0 without ALU_OVF_EN)
//   - ADDU -> ovf=0
//   - SUB with a=b=5 -> out=0, alu_zero=1
// - alu_a=32'hFFFFFFFF, alu_b=1:
//   - SLT -> 1; SLTU -> 0
//   - SRA with a=4, b=32'h80000000 -> 32'hF8000000
//   - LUI with b=32'h1234 -> 32'h12340000
// - SW 32'hAABBCCDD to addr 8, then:
//   - LB addr 9 -> 32'hFFFFFFCC; LBU addr 11 -> 32'h000000AA
//   - LH addr 10 -> 32'hFFFFAABB; LW addr 8 -> 32'hAABBCCDD
// - SB 32'h11 to addr 9 over the word above -> LW 8 = 32'hAABB11DD; SH 32'h2233 to addr 8 -> 32'hAABB2233.
// - Store to addr 8 + (4<<DM_AW) -> visible at addr 8 (wrap).
// - Pull reset=0 for one edge with mem_wr=1 -> all read 0 and the write is dropped.

Source files
------------

// File: rtl/exec_pkg.sv
// exec_pkg: shared ALU operation codes and memory opcode constants
package exec_pkg;
    localparam logic [4:0] ALU_ADDU = 5'd0;
    localparam logic [4:0] ALU_ADD  = 5'd1;
    localparam logic [4:0] ALU_SUBU = 5'd2;
    localparam logic [4:0] ALU_SUB  = 5'd3;
    localparam logic [4:0] ALU_AND  = 5'd4;
    localparam logic [4:0] ALU_OR   = 5'd5;
    localparam logic [4:0] ALU_XOR  = 5'd6;
    localparam logic [4:0] ALU_NOR  = 5'd7;
    localparam logic [4:0] ALU_SLT  = 5'd8;
    localparam logic [4:0] ALU_SLTU = 5'd9;
    localparam logic [4:0] ALU_SLL  = 5'd10;
    localparam logic [4:0] ALU_SRL  = 5'd11;
    localparam logic [4:0] ALU_SRA  = 5'd12;
    localparam logic [4:0] ALU_LUI  = 5'd13;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
endpackage

// File: rtl/exec_dm_ram.sv
// exec_dm_ram: byte-lane-enable word RAM with synchronous active-low clear and asynchronous read
module exec_dm_ram #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [2**AW];
    assign rdata = mem[addr];
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
        end else begin
            for (int j = 0; j < 4; j++) if (we[j]) mem[addr][8*j +: 8] <= wdata[8*j +: 8];
        end
    end
endmodule

// File: rtl/exec_mem_unit.sv
// exec_mem_unit: immediate extender, ALU and byte-addressed data memory; ALU_OVF_EN enables signed overflow flag
module exec_mem_unit
    import exec_pkg::*;
#(
    parameter int DM_AW = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ext_op,
    input  logic [15:0] imm16,
    output logic [31:0] ext_out,
    input  logic [31:0] alu_a,
    input  logic [31:0] alu_b,
    input  logic [4:0]  alu_ctr,
    output logic [31:0] alu_out,
    output logic        alu_zero,
    output logic        alu_ovf,
    input  logic        mem_wr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [5:0]  mem_opcode,
    output logic [31:0] mem_rdata
);
    logic [31:0] sum, diff, word;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic        unused_addr;

    assign ext_out = ext_op ? {{16{imm16[15]}}, imm16} : {16'b0, imm16};
    assign sum  = alu_a + alu_b;
    assign diff = alu_a - alu_b;

    always_comb begin
        alu_out = '0;
        case (alu_ctr)
            ALU_ADDU, ALU_ADD: alu_out = sum;
            ALU_SUBU, ALU_SUB: alu_out = diff;
            ALU_AND:  alu_out = alu_a & alu_b;
            ALU_OR:   alu_out = alu_a | alu_b;
            ALU_XOR:  alu_out = alu_a ^ alu_b;
            ALU_NOR:  alu_out = ~(alu_a | alu_b);
            ALU_SLT:  alu_out = {31'b0, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU: alu_out = {31'b0, alu_a < alu_b};
            ALU_SLL:  alu_out = alu_b << alu_a[4:0];
            ALU_SRL:  alu_out = alu_b >> alu_a[4:0];
            ALU_SRA:  alu_out = $signed(alu_b) >>> alu_a[4:0];
            ALU_LUI:  alu_out = {alu_b[15:0], 16'b0};
            default:  alu_out = '0;
        endcase
    end

    assign alu_zero = (alu_out == '0);

`ifdef ALU_OVF_EN
    assign alu_ovf = (alu_ctr == ALU_ADD && alu_a[31] == alu_b[31] && sum[31]  != alu_a[31]) ||
                     (alu_ctr == ALU_SUB && alu_a[31] != alu_b[31] && diff[31] != alu_a[31]);
`else
    assign alu_ovf = 1'b0;
`endif

    assign we = !mem_wr ? 4'b0000 :
                mem_opcode == OP_SB ? 4'b0001 << mem_addr[1:0] :
                mem_opcode == OP_SH ? (mem_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wdata = mem_opcode == OP_SB ? {4{mem_wdata[7:0]}} :
                   mem_opcode == OP_SH ? {2{mem_wdata[15:0]}} : mem_wdata;

    exec_dm_ram #(.AW(DM_AW)) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .addr  (mem_addr[DM_AW+1:2]),
        .wdata (wdata),
        .rdata (word)
    );

    assign byte_v = word[8*mem_addr[1:0] +: 8];
    assign half_v = mem_addr[1] ? word[31:16] : word[15:0];
    assign mem_rdata = mem_opcode == OP_LB  ? {{24{byte_v[7]}}, byte_v} :
                       mem_opcode == OP_LBU ? {24'b0, byte_v} :
                       mem_opcode == OP_LH  ? {{16{half_v[15]}}, half_v} :
                       mem_opcode == OP_LHU ? {16'b0, half_v} : word;
    assign unused_addr = ^mem_addr[31:DM_AW+2];
endmodule

// File: tb/tb_exec_mem_unit.sv
// tb_exec_mem_unit: scoreboard-driven self-checking bench for exec_mem_unit
module tb_exec_mem_unit;
    localparam int DM_AW = 10;
`ifdef ALU_OVF_EN
    localparam logic OVF = 1'b1;
`else
    localparam logic OVF = 1'b0;
`endif
    localparam logic [5:0] LW = 6'h23, SW = 6'h2B, LB = 6'h20, LBU = 6'h24, LH = 6'h21, LHU = 6'h25, SB = 6'h28, SH = 6'h29;

    logic        clk = 0, reset = 0, ext_op = 0, mem_wr = 0;
    logic [15:0] imm16 = '0;
    logic [31:0] ext_out, alu_a = '0, alu_b = '0, alu_out, mem_addr = '0, mem_wdata = '0, mem_rdata;
    logic [4:0]  alu_ctr = '0;
    logic        alu_zero, alu_ovf;
    logic [5:0]  mem_opcode = LW;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;
    sb_t sb[$];
    int errors = 0, checks = 0;

    exec_mem_unit #(.DM_AW(DM_AW)) dut (
        .clk(clk), .reset(reset), .ext_op(ext_op), .imm16(imm16), .ext_out(ext_out),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr), .alu_out(alu_out),
        .alu_zero(alu_zero), .alu_ovf(alu_ovf), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_opcode(mem_opcode), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] exp);
        sb.push_back('{tag, exp});
    endtask

    task automatic pop_check(input logic [31:0] got);
        sb_t t;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            t = sb.pop_front();
            check(t.tag, got, t.exp);
        end
    endtask

    task automatic ext(input logic op, input logic [15:0] imm, input logic [31:0] e);
        @(negedge clk);
        ext_op = op;
        imm16 = imm;
        push($sformatf("ext op%0d", op), e);
        #1 pop_check(ext_out);
    endtask

    task automatic alu(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e, input logic e_ovf);
        @(negedge clk);
        alu_ctr = c;
        alu_a = a;
        alu_b = b;
        push($sformatf("alu_out c%0d", c), e);
        push($sformatf("alu_zero c%0d", c), {31'b0, e == 32'd0});
        push($sformatf("alu_ovf c%0d", c), {31'b0, e_ovf});
        #1;
        pop_check(alu_out);
        pop_check({31'b0, alu_zero});
        pop_check({31'b0, alu_ovf});
    endtask

    task automatic st(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        mem_wr = 1;
        mem_opcode = op;
        mem_addr = a;
        mem_wdata = d;
        @(posedge clk);
        #1 mem_wr = 0;
    endtask

    task automatic ld(input logic [5:0] op, input logic [31:0] a, input logic [31:0] e);
        @(negedge clk);
        mem_opcode = op;
        mem_addr = a;
        push($sformatf("ld op%h a%0d", op, a), e);
        #1 pop_check(mem_rdata);
    endtask

    initial begin
        @(posedge clk);
        #1 reset = 1;
        ld(LW, 8, 32'h0);
        ld(LW, 0, 32'h0);
        ext(1, 16'h8001, 32'hFFFF8001);
        ext(0, 16'h8001, 32'h00008001);
        ext(1, 16'h7FFF, 32'h00007FFF);
        alu(1, 32'h7FFFFFFF, 1, 32'h80000000, OVF);
        alu(0, 32'h7FFFFFFF, 1, 32'h80000000, 0);
        alu(3, 5, 5, 0, 0);
        alu(3, 32'h80000000, 1, 32'h7FFFFFFF, OVF);
        alu(2, 32'h80000000, 1, 32'h7FFFFFFF, 0);
        alu(8, 32'hFFFFFFFF, 1, 1, 0);
        alu(9, 32'hFFFFFFFF, 1, 0, 0);
        alu(12, 4, 32'h80000000, 32'hF8000000, 0);
        alu(11, 4, 32'h80000000, 32'h08000000, 0);
        alu(10, 36, 32'h00000003, 32'h00000030, 0);
        alu(13, 0, 32'h1234, 32'h12340000, 0);
        alu(4, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0);
        alu(5, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 0);
        alu(6, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 0);
        alu(7, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h0, 0);
        alu(20, 32'h12345678, 32'h1, 32'h0, 0);
        st(SW, 8, 32'hAABBCCDD);
        ld(LB, 9, 32'hFFFFFFCC);
        ld(LBU, 11, 32'h000000AA);
        ld(LH, 10, 32'hFFFFAABB);
        ld(LHU, 10, 32'h0000AABB);
        ld(LW, 8, 32'hAABBCCDD);
        @(negedge clk);
        mem_wr = 1;
        mem_opcode = SB;
        mem_addr = 9;
        mem_wdata = 32'h11;
        push("rdw_old", 32'hAABBCCDD);
        #1 pop_check(mem_rdata);
        @(posedge clk);
        push("rdw_new", 32'hAABB11DD);
        #1 pop_check(mem_rdata);
        mem_wr = 0;
        ld(LW, 8, 32'hAABB11DD);
        st(SH, 8, 32'h2233);
        ld(LW, 8, 32'hAABB2233);
        st(SW, 8 + (4 << DM_AW), 32'h55667788);
        ld(LW, 8, 32'h55667788);
        st(SW, 12, 32'hDEADBEEF);
        ld(LW, 12, 32'hDEADBEEF);
        @(negedge clk);
        reset = 0;
        mem_wr = 1;
        mem_opcode = SW;
        mem_addr = 16;
        mem_wdata = 32'h1;
        @(posedge clk);
        #1 mem_wr = 0;
        reset = 1;
        ld(LW, 8, 32'h0);
        ld(LW, 12, 32'h0);
        ld(LW, 16, 32'h0);
        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
